usermem_resp: RTL
=================

USERMEM_RESP -- requirements
Module: usermem_resp

Interface
REQ-001 SHALL have parameter RAM_TOP, default 8'hEF, highest RAM byte address.
REQ-002 SHALL have parameter IO_BASE, default 8'hF0, base address of the timer register block.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port rw, input, 1, CPU direction: 1 = CPU reads (responder drives), 0 = CPU writes.
REQ-006 SHALL have port usermem_address, input, 8, byte address from the CPU.
REQ-007 SHALL have port usermem_data, inout, 8, bidirectional data bus shared with the CPU.
REQ-008 SHALL have port interrupt, output, 1, timer interrupt request to the CPU.

Function
REQ-009 SHALL decode the address map as follows: 0x00..RAM_TOP = RAM; IO_BASE+0 = LOAD (R/W); +1 = COUNT (RO); +2 = CTRL (R/W); +3 = STATUS (R/W1C); IO_BASE+4..0xFF = unmapped.
REQ-010 SHALL drive usermem_data with the read value only while rw=1, and SHALL hold it at high-Z while rw=0 or while reset is low.
REQ-011 SHALL return read data combinationally in the same cycle as the address (zero-cycle read latency); reads SHALL have no side effects.
REQ-012 SHALL perform writes on the rising clk edge when rw=0; the written value SHALL be visible to a read in the next cycle.
REQ-013 SHALL read unmapped addresses as 8'h00 and SHALL ignore writes to them.
REQ-014 SHALL ignore writes to COUNT.
REQ-015 SHALL define CTRL bits as: bit0 EN (timer run), bit1 AR (auto-reload), bit2 IE (interrupt enable); bits 7:3 SHALL read as 0.
REQ-016 SHALL define STATUS bit0 as PEND; bits 7:1 SHALL read as 0; writing 1 to bit0 SHALL clear PEND and writing 0 SHALL have no effect.
REQ-017 SHALL, on a write to LOAD, store the value in LOAD and also copy it into COUNT on the same edge.
REQ-018 SHALL apply the following rules on each edge where EN=1 and no LOAD write occurs: if COUNT≠0, COUNT←COUNT−1; if COUNT=0 this is an expiry.
REQ-019 SHALL, on expiry, set PEND; if AR=1 it SHALL set COUNT←LOAD and keep EN=1; if AR=0 it SHALL keep COUNT at 0 and clear EN.
REQ-020 SHALL, as a consequence of REQ-018 and REQ-019, make the first expiry occur on the (N+1)th enabled edge after LOAD=N, and SHALL treat LOAD=0 with AR=1 as expiring on every enabled edge.
REQ-021 SHALL let a LOAD write take priority over a decrement or expiry on the same edge (COUNT←new value, no expiry).
REQ-022 SHALL let an expiry take priority over a simultaneous STATUS W1C, leaving PEND=1.
REQ-023 SHALL let an expiry's automatic EN clear take priority over a simultaneous CTRL write that sets EN; other CTRL bits SHALL take the written value.
REQ-024 SHALL generate interrupt = PEND AND IE, from flops only, with no combinational path from any input.

Reset
REQ-025 SHALL, while reset=0, immediately and asynchronously force LOAD=0, COUNT=0, CTRL=0, PEND=0 and interrupt=0, and SHALL float the data bus.
REQ-026 SHALL NOT reset RAM contents; RAM reads before a first write SHALL be undefined.
REQ-027 SHALL discard any operation in progress when reset asserts mid-operation; counting SHALL resume only after software sets EN again.

Structure
REQ-028 SHALL place the register offsets (LOAD/COUNT/CTRL/STATUS), the CTRL and STATUS bit positions, and the default RAM_TOP/IO_BASE values in the shared package usermem_pkg.
REQ-029 SHALL contain exactly one sub-module, timer8, holding LOAD, COUNT, EN/AR/IE, PEND and the expiry logic; the RAM array, address decode and tristate control SHALL stay in usermem_resp.

Verification
REQ-030 SHALL cover the following RAM scenario: write 0xA5@0x10 then 0x3C@0xEF, read both -> 0xA5, 0x3C; bus is high-Z in every rw=0 cycle.
REQ-031 SHALL cover the following unmapped scenario: write 0xFF@0xF8, read 0xF8 -> 0x00; write 0x55@0xF1 -> COUNT unchanged.
REQ-032 SHALL cover the following one-shot scenario: LOAD=3, CTRL=0x05 -> PEND and interrupt rise on the 4th enabled edge; afterwards CTRL reads 0x04 and COUNT reads 0.
REQ-033 SHALL cover the following auto-reload scenario: LOAD=2, CTRL=0x03 -> PEND sets every 3 edges, COUNT sequence is 2,1,0,2,1,0; interrupt stays 0 because IE=0.
REQ-034 SHALL cover the following collision scenarios: W1C STATUS on the expiry edge -> PEND stays 1; LOAD write on the expiry edge -> no expiry and COUNT = new value.
REQ-035 SHALL cover the following reset scenario: assert reset mid-count with COUNT=5 -> all registers read 0, interrupt=0 asynchronously, and previously written RAM data is retained.

Source files
------------

// File: rtl/usermem_pkg.sv
// Shared constants and types for the user-memory responder and its timer block.
package usermem_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    localparam logic [ADDR_W-1:0] RAM_TOP_DEF = 8'hEF;
    localparam logic [ADDR_W-1:0] IO_BASE_DEF = 8'hF0;

    localparam logic [1:0] OFF_LOAD   = 2'd0;
    localparam logic [1:0] OFF_COUNT  = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_AR     = 1;
    localparam int unsigned CTRL_IE     = 2;
    localparam int unsigned STATUS_PEND = 0;

    typedef struct packed {
        logic ie;
        logic ar;
        logic en;
    } timer_ctrl_t;

endpackage

// File: rtl/timer8.sv
// 8-bit down-counting timer with optional auto-reload, sticky pending flag
// and a registered interrupt request.
module timer8
    import usermem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_we,
    input  logic              ctrl_we,
    input  logic              status_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load,
    output logic [DATA_W-1:0] count,
    output timer_ctrl_t       ctrl,
    output logic              pend,
    output logic              irq
);

    logic [DATA_W-1:0] load_nxt;
    logic [DATA_W-1:0] count_nxt;
    timer_ctrl_t       ctrl_nxt;
    logic              pend_nxt;
    logic              irq_nxt;

    // Priority: LOAD write beats count/expiry; expiry beats W1C and CTRL's EN set.
    always_comb begin
        load_nxt  = load;
        count_nxt = count;
        ctrl_nxt  = ctrl;
        pend_nxt  = pend;

        if (ctrl_we) begin
            ctrl_nxt.en = wdata[CTRL_EN];
            ctrl_nxt.ar = wdata[CTRL_AR];
            ctrl_nxt.ie = wdata[CTRL_IE];
        end

        if (status_we && wdata[STATUS_PEND]) begin
            pend_nxt = 1'b0;
        end

        if (load_we) begin
            load_nxt  = wdata;
            count_nxt = wdata;
        end else if (ctrl.en) begin
            if (count != '0) begin
                count_nxt = count - DATA_W'(1);
            end else begin
                pend_nxt = 1'b1;
                if (ctrl.ar) begin
                    count_nxt = load;
                end else begin
                    count_nxt   = '0;
                    ctrl_nxt.en = 1'b0;
                end
            end
        end

        irq_nxt = pend_nxt & ctrl_nxt.ie;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load  <= '0;
            count <= '0;
            ctrl  <= '0;
            pend  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            load  <= load_nxt;
            count <= count_nxt;
            ctrl  <= ctrl_nxt;
            pend  <= pend_nxt;
            irq   <= irq_nxt;
        end
    end

endmodule

// File: rtl/usermem_resp.sv
// CPU-facing memory responder: byte RAM, timer register block and a shared
// tristate data bus with zero-cycle read latency.
module usermem_resp
    import usermem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RAM_TOP = RAM_TOP_DEF,
    parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rw,
    input  logic [ADDR_W-1:0] usermem_address,
    inout  wire  [DATA_W-1:0] usermem_data,
    output logic              interrupt
);

    logic [DATA_W-1:0] ram [0:RAM_TOP];

    logic [ADDR_W:0]   addr_ext_c;
    logic              is_ram_c;
    logic              io_hit_c;
    logic [1:0]        io_off_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              ram_we_c;

    logic [DATA_W-1:0] tmr_load;
    logic [DATA_W-1:0] tmr_count;
    timer_ctrl_t       tmr_ctrl;
    logic              tmr_pend;
    logic              tmr_irq;

    // Address decode; RAM wins if the two windows are ever configured to overlap.
    always_comb begin
        addr_ext_c = {1'b0, usermem_address};
        is_ram_c   = (usermem_address <= RAM_TOP);
        io_hit_c   = !is_ram_c
                     && (addr_ext_c >= (ADDR_W+1)'(IO_BASE))
                     && (addr_ext_c <= (ADDR_W+1)'(IO_BASE) + (ADDR_W+1)'(3));
        io_off_c   = 2'(usermem_address - IO_BASE);
        ram_we_c   = !rw && is_ram_c;
    end

    // RAM has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram[usermem_address] <= usermem_data;
        end
    end

    timer8 u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .load_we   (!rw && io_hit_c && (io_off_c == OFF_LOAD)),
        .ctrl_we   (!rw && io_hit_c && (io_off_c == OFF_CTRL)),
        .status_we (!rw && io_hit_c && (io_off_c == OFF_STATUS)),
        .wdata     (usermem_data),
        .load      (tmr_load),
        .count     (tmr_count),
        .ctrl      (tmr_ctrl),
        .pend      (tmr_pend),
        .irq       (tmr_irq)
    );

    // Read mux; unmapped space returns zero.
    always_comb begin
        rd_data_c = '0;
        if (is_ram_c) begin
            rd_data_c = ram[usermem_address];
        end else if (io_hit_c) begin
            case (io_off_c)
                OFF_LOAD:   rd_data_c = tmr_load;
                OFF_COUNT:  rd_data_c = tmr_count;
                OFF_CTRL:   rd_data_c = DATA_W'(tmr_ctrl);
                OFF_STATUS: rd_data_c = DATA_W'(tmr_pend);
                default:    rd_data_c = '0;
            endcase
        end
    end

    assign usermem_data = (rw && reset) ? rd_data_c : {DATA_W{1'bz}};
    assign interrupt    = tmr_irq;

endmodule
